// File: rtl/tdpram_rd_sched.sv
// Round-robin scheduler sharing the read-only port B of the dual-port RAM among NUM_REQ
// requesters; each returned word is steered back to its requester by a tag pipeline.
module tdpram_rd_sched #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LAT     = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic                          i_hold,
  output logic                          o_ram_en_b,
  output logic [ADDR_WIDTH-1:0]         o_ram_addr_b,
  input  logic [DATA_WIDTH-1:0]         i_ram_data_b,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_busy
);

  logic [ID_WIDTH-1:0]               rr_ptr_q, rr_ptr_d;
  logic                              ram_en_q, ram_en_d;
  logic [ADDR_WIDTH-1:0]             ram_addr_q, ram_addr_d;
  logic [RD_LAT:0]                   tag_vld_q, tag_vld_d;
  logic [RD_LAT:0][ID_WIDTH-1:0]     tag_id_q, tag_id_d;
  logic [NUM_REQ-1:0]                rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]             rsp_data_q, rsp_data_d;

  logic                              gnt_any;
  logic [ID_WIDTH-1:0]               gnt_id;
  logic [NUM_REQ-1:0]                gnt;
  logic [ADDR_WIDTH-1:0]             gnt_addr;
  int                                idx;
  logic [ID_WIDTH-1:0]               idx_sel;

  // First valid requester at or above the pointer, with wrap.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    gnt     = '0;
    idx     = 0;
    idx_sel = '0;
    if (!i_hold) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = int'(rr_ptr_q) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        idx_sel = idx[ID_WIDTH-1:0];
        if (!gnt_any && i_req_valid[idx_sel]) begin
          gnt_any = 1'b1;
          gnt_id  = idx_sel;
        end
      end
    end
    if (gnt_any) gnt[gnt_id] = 1'b1;
  end

  assign gnt_addr    = i_req_addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
  assign o_req_ready = gnt;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + ID_WIDTH'(1);
    end

    ram_en_d   = gnt_any;
    ram_addr_d = gnt_any ? gnt_addr : ram_addr_q;

    // Stage 0 travels with the RAM enable; stage RD_LAT lines up with read data.
    tag_vld_d    = {tag_vld_q[RD_LAT-1:0], gnt_any};
    tag_id_d     = tag_id_q;
    tag_id_d[0]  = gnt_id;
    for (int s = 1; s <= RD_LAT; s++) begin
      tag_id_d[s] = tag_id_q[s-1];
    end

    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_vld_q[RD_LAT]) begin
      rsp_valid_d[tag_id_q[RD_LAT]] = 1'b1;
      rsp_data_d                    = i_ram_data_b;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr_q    <= '0;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      ram_en_q    <= ram_en_d;
      ram_addr_q  <= ram_addr_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign o_ram_en_b   = ram_en_q;
  assign o_ram_addr_b = ram_addr_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_data   = rsp_data_q;
  assign o_busy       = (|tag_vld_q) | ram_en_q;

endmodule

// File: tb/tb_tdpram_rd_sched.sv
// Directed bench for tdpram_rd_sched with a two-cycle-latency RAM port-B model.
module tb_tdpram_rd_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [39:0] req_addr;
  logic [3:0]  req_ready;
  logic        hold;
  logic        ram_en;
  logic [9:0]  ram_addr;
  logic [31:0] ram_data;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;

  logic [31:0] mem [0:1023];
  logic [31:0] ram_r1;

  int checks;
  int failures;

  tdpram_rd_sched #(
    .NUM_REQ(4), .ID_WIDTH(2), .DATA_WIDTH(32), .ADDR_WIDTH(10), .RD_LAT(2)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .i_req_addr   (req_addr),
    .o_req_ready  (req_ready),
    .i_hold       (hold),
    .o_ram_en_b   (ram_en),
    .o_ram_addr_b (ram_addr),
    .i_ram_data_b (ram_data),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_data   (rsp_data),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM read register followed by one output delay register.
  always @(posedge clk) begin
    if (ram_en) ram_r1 <= mem[ram_addr];
    ram_data <= ram_r1;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    hold      = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (ram_en !== 1'b0 || ram_addr !== 10'h0 || rsp_valid !== 4'h0 || rsp_data !== 32'h0
        || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs en=%b addr=%h rv=%b rd=%h busy=%b required all zero",
               ram_en, ram_addr, rsp_valid, rsp_data, busy);
    end
    checks++;
    if (dut.rr_ptr_q !== 2'd0) begin
      failures++;
      $display("FAIL reset_ptr got %0d required 0", dut.rr_ptr_q);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001;
    req_addr[9:0] = 10'h005;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_ready got %b required 0001", req_ready);
    end
    next_cycle();
    req_valid = '0;
    #1;
    checks++;
    if (ram_en !== 1'b1 || ram_addr !== 10'h005) begin
      failures++;
      $display("FAIL single_issue en=%b addr=%h required 1 005", ram_en, ram_addr);
    end
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (busy !== 1'b1 || rsp_valid !== 4'b0000) begin
        failures++;
        $display("FAIL single_busy T+%0d busy=%b rv=%b required 1 0000", c, busy, rsp_valid);
      end
      next_cycle();
      #1;
    end
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 32'hDEADBEEF || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp rv=%b rd=%h busy=%b required 0001 deadbeef 0",
               rsp_valid, rsp_data, busy);
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp_rv;
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) req_addr[k*10 +: 10] = 10'(16 + k);
    for (int c = 0; c < 9; c++) begin
      if (c == 8) req_valid = '0;
      #1;
      if (c < 8) begin
        checks++;
        if (req_ready !== 4'(1 << (c % 4))) begin
          failures++;
          $display("FAIL contention_ready c=%0d got %b required %b", c, req_ready,
                   4'(1 << (c % 4)));
        end
      end
      exp_rv = (c >= 4) ? 4'(1 << ((c - 4) % 4)) : 4'b0000;
      checks++;
      if (rsp_valid !== exp_rv || (c >= 4 && rsp_data !== 32'(16 + (c - 4) % 4))) begin
        failures++;
        $display("FAIL contention_rsp c=%0d rv=%b rd=%h required %b %h", c, rsp_valid,
                 rsp_data, exp_rv, 32'(16 + (c - 4) % 4));
      end
      next_cycle();
    end
    req_valid = '0;
  endtask

  task automatic test_fairness();
    do_reset();
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL fair_first got %b required 0100", req_ready);
    end
    next_cycle();
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL fair_second got %b required 1000", req_ready);
    end
    next_cycle();
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL fair_third got %b required 0010", req_ready);
    end
    next_cycle();
    req_valid = '0;
    #1;
    checks++;
    if (dut.rr_ptr_q !== 2'd2) begin
      failures++;
      $display("FAIL fair_ptr got %0d required 2", dut.rr_ptr_q);
    end
  endtask

  task automatic test_hold();
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) req_addr[k*10 +: 10] = 10'(16 + k);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL hold_pre got %b required 0001", req_ready);
    end
    next_cycle();
    hold = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000 || (c >= 2 && ram_en !== 1'b0)) begin
        failures++;
        $display("FAIL hold_block T+%0d ready=%b en=%b required 0000 0", c, req_ready, ram_en);
      end
      if (c == 4) begin
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_data !== 32'h10) begin
          failures++;
          $display("FAIL hold_rsp rv=%b rd=%h required 0001 00000010", rsp_valid, rsp_data);
        end
      end
      next_cycle();
    end
    hold = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL hold_resume got %b required 0010", req_ready);
    end
    next_cycle();
    req_valid = '0;
    #1;
    checks++;
    if (ram_en !== 1'b1 || ram_addr !== 10'h011) begin
      failures++;
      $display("FAIL hold_issue en=%b addr=%h required 1 011", ram_en, ram_addr);
    end
    for (int c = 0; c < 5; c++) next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) req_addr[k*10 +: 10] = 10'(16 + k);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    req_valid = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || ram_en !== 1'b0 || dut.rr_ptr_q !== 2'd0) begin
      failures++;
      $display("FAIL rstmid_state busy=%b en=%b ptr=%0d required 0 0 0", busy, ram_en,
               dut.rr_ptr_q);
    end
    for (int c = 3; c <= 6; c++) begin
      checks++;
      if (rsp_valid !== 4'b0000) begin
        failures++;
        $display("FAIL rstmid_rsp T+%0d got %b required 0000", c, rsp_valid);
      end
      next_cycle();
      #1;
    end
  endtask

  task automatic test_stream();
    logic [3:0] exp_rv;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c < 5) begin
        req_valid = 4'b0010;
        req_addr[19:10] = 10'(c);
      end else begin
        req_valid = '0;
      end
      #1;
      if (c < 5) begin
        checks++;
        if (req_ready !== 4'b0010) begin
          failures++;
          $display("FAIL stream_ready c=%0d got %b required 0010", c, req_ready);
        end
      end
      exp_rv = (c >= 4 && c < 9) ? 4'b0010 : 4'b0000;
      checks++;
      if (rsp_valid !== exp_rv || (exp_rv != 4'b0000 && rsp_data !== 32'(c - 4))) begin
        failures++;
        $display("FAIL stream_rsp c=%0d rv=%b rd=%h required %b %h", c, rsp_valid, rsp_data,
                 exp_rv, 32'(c - 4));
      end
      next_cycle();
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    hold      = 1'b0;
    ram_r1    = '0;
    ram_data  = '0;
    for (int a = 0; a < 1024; a++) mem[a] = 32'(a);
    mem[5] = 32'hDEADBEEF;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_hold();
    test_reset_mid();
    test_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdpram_rd_sched.md
Name: tdpram_rd_sched

Overview:
- Round-robin read scheduler that shares the read-only port B of the team's dual-port RAM wrapper among NUM_REQ requesters.
- Accepts one read request per cycle and drives the RAM port-B enable and address from registers.
- Tracks in-flight reads in a tag pipeline and returns each read word, one-hot tagged, to the requester that issued it.
- Sits between per-queue lookup logic and the RAM instance; port A (writer) is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, width of requester index; must equal clog2(NUM_REQ).
- DATA_WIDTH, 32, RAM word width.
- ADDR_WIDTH, 10, RAM address width.
- RD_LAT, 2, cycles from o_ram_en_b high to valid i_ram_data_b (RAM read register + OUT_DELAY=1).

Ports:
- i_clk  in  1  single clock for block and RAM port B.
- i_rst  in  1  reset, synchronous, active-high.
- i_req_valid  in  NUM_REQ  per-requester read request.
- i_req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- o_req_ready  out  NUM_REQ  one-hot grant; handshake when valid&ready.
- i_hold  in  1  suppresses new grants; in-flight reads still complete.
- o_ram_en_b  out  1  RAM port-B enable (registered).
- o_ram_addr_b  out  ADDR_WIDTH  RAM port-B address (registered).
- i_ram_data_b  in  DATA_WIDTH  RAM port-B read data.
- o_rsp_valid  out  NUM_REQ  one-hot response strobe (registered).
- o_rsp_data  out  DATA_WIDTH  response word, shared by all requesters (registered).
- o_busy  out  1  high while any read is in flight.

Behaviour:
- Interface: one clock, i_clk; reset i_rst is synchronous and active-high.
- Reset values:
  - o_ram_en_b=0, o_ram_addr_b=0, o_rsp_valid=0, o_rsp_data=0, o_busy=0.
  - RR pointer=0; tag pipeline cleared.
- Grant (combinational from registered state):
  - If i_hold=0 and any i_req_valid, grant the first requester with valid high, searching from the RR pointer upward with wrap.
  - o_req_ready is one-hot for the granted requester only; all zeros when i_hold=1 or no request.
  - o_req_ready never depends on anything but i_req_valid, i_hold and the pointer.
- Pointer: on each grant, pointer <= (granted index + 1) mod NUM_REQ; otherwise unchanged.
- Issue: a grant in cycle T gives o_ram_en_b=1 and o_ram_addr_b=granted address in T+1. With no grant, o_ram_en_b=0 and o_ram_addr_b holds its value.
- Tag pipeline:
  - RD_LAT+1 stages of {valid, id}; stage 0 is loaded alongside o_ram_en_b.
  - Stage RD_LAT aligns with valid i_ram_data_b.
- Response:
  - Register i_ram_data_b into o_rsp_data when the aligned tag is valid.
  - o_rsp_valid = one-hot(id) in T+2+RD_LAT (T+4 at default); otherwise 0, and o_rsp_data holds.
- Throughput: fully pipelined, one grant and one response per cycle max. No response backpressure; requesters must accept o_rsp_valid unconditionally.
- Ordering: responses return in grant order.
- o_busy = OR of all tag-pipeline valid bits and o_ram_en_b.
- The same requester may be granted every cycle when it is the only one requesting.
- i_hold asserted mid-stream:
  - Takes effect the same cycle; no grant is issued.
  - Already-issued reads still respond at their scheduled cycles.
- Reset during activity:
  - Pipeline is flushed; in-flight reads never produce o_rsp_valid.
  - Outputs take reset values in the cycle after i_rst is sampled high.
- Requester valid dropping without a handshake is legal; no state is retained.
- Hazards with port-A writes to the same address are not detected. Read returns whatever the RAM outputs.

Test Plan:
- Single read: mem[0x005]=0xDEADBEEF; req0 valid addr 0x005 at T -> o_req_ready=0001 at T; o_ram_en_b=1, addr 0x005 at T+1; o_rsp_valid=0001, o_rsp_data=0xDEADBEEF at T+4; o_busy high T+1..T+3, low T+4.
- Full contention: all 4 valid continuously, mem[a]=a, addr k=0x10+k -> grants 0,1,2,3,0,... one per cycle; responses 0x10,0x11,0x12,0x13 on o_rsp_valid 0001,0010,0100,1000 in consecutive cycles from T+4.
- Pointer fairness: grant to 2, then req1 and req3 both valid -> req3 granted first, req1 next cycle, pointer=2 after.
- Hold: i_hold=1 at T+1 during continuous requests -> o_req_ready=0 from T+1; read granted at T still responds at T+4; grants resume the cycle after i_hold=0.
- Reset mid-flight: grants at T and T+1, i_rst=1 at T+2 -> o_rsp_valid stays 0 through T+6; pointer=0, o_busy=0 at T+3.
- Single-requester streaming: only req1 valid for 5 cycles with addrs 0..4 -> granted every cycle; 5 back-to-back responses on o_rsp_valid=0010 in order.
